// File: rtl/convertidor_bcd_binario_param.sv
// Parametrised sequential BCD -> two's-complement binary converter.
// Reverse double-dabble: one shift per clock, with a -3 correction on every BCD digit >= 8.
// A capture containing any non-decimal digit skips conversion and reports error_bcd.
module convertidor_bcd_binario_param #(
    parameter int DIGITOS   = 5,
    parameter int ANCHO_BIN = 17
) (
    input  logic                   reloj,
    input  logic                   reset,
    input  logic                   inicio,
    input  logic                   signo,
    input  logic [4*DIGITOS-1:0]   entrada_bcd,
    output logic [ANCHO_BIN:0]     resultado_bin,
    output logic                   terminado,
    output logic                   ocupado,
    output logic                   error_bcd
);

    localparam int ANCHO_BCD = 4 * DIGITOS;
    localparam int ANCHO_CNT = $clog2(ANCHO_BCD + 1);
    localparam logic [ANCHO_CNT-1:0] ULTIMO = ANCHO_CNT'(ANCHO_BCD - 1);

    localparam logic [1:0] REPOSO    = 2'd0;
    localparam logic [1:0] CONVERTIR = 2'd1;
    localparam logic [1:0] FIN       = 2'd2;
    localparam logic [1:0] FIN_ERR   = 2'd3;

    // Largest decimal magnitude must fit in the magnitude width.
    localparam longint unsigned MAX_DEC   = (64'd10 ** DIGITOS) - 64'd1;
    localparam longint unsigned CAPACIDAD = 64'd1 << ANCHO_BIN;

    if (DIGITOS < 1 || DIGITOS > 9 || CAPACIDAD <= MAX_DEC) begin : g_param_invalido
        $error("convertidor_bcd_binario_param: ANCHO_BIN too small for DIGITOS");
    end

    logic [1:0]           estado;
    logic [ANCHO_CNT-1:0] contador;
    logic [ANCHO_BCD-1:0] bcd_reg;
    logic [ANCHO_BCD-1:0] bin_reg;
    logic                 signo_reg;
    logic                 inicio_d;

    logic                 arranque;
    logic                 digito_invalido;
    logic [ANCHO_BCD-1:0] bcd_desp;
    logic [ANCHO_BCD-1:0] bcd_corr;
    logic [ANCHO_BCD-1:0] bin_desp;
    logic [ANCHO_BIN-1:0] magnitud;
    logic [ANCHO_BIN:0]   mag_ext;
    logic [ANCHO_BIN:0]   resultado_sig;

    assign arranque = inicio & ~inicio_d & (estado == REPOSO);

    // Flag any input digit outside 0..9.
    always_comb begin
        digito_invalido = 1'b0;
        for (int i = 0; i < DIGITOS; i++) begin
            if (entrada_bcd[4*i +: 4] > 4'h9) digito_invalido = 1'b1;
        end
    end

    // One reverse double-dabble step: shift right, then correct digits that crossed 8.
    always_comb begin
        {bcd_desp, bin_desp} = {bcd_reg, bin_reg} >> 1;
        bcd_corr = bcd_desp;
        for (int i = 0; i < DIGITOS; i++) begin
            if (bcd_desp[4*i +: 4] >= 4'h8) bcd_corr[4*i +: 4] = bcd_desp[4*i +: 4] - 4'h3;
        end
    end

    // Magnitude zero-extended by one bit, then negated when the operand is negative.
    always_comb begin
        magnitud      = ANCHO_BIN'(bin_reg);
        mag_ext       = {1'b0, magnitud};
        resultado_sig = signo_reg ? -mag_ext : mag_ext;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            estado        <= REPOSO;
            contador      <= '0;
            bcd_reg       <= '0;
            bin_reg       <= '0;
            signo_reg     <= 1'b0;
            inicio_d      <= 1'b1;  // inicio held through reset must fall before it can start
            resultado_bin <= '0;
            terminado     <= 1'b0;
            ocupado       <= 1'b0;
            error_bcd     <= 1'b0;
        end else begin
            inicio_d  <= inicio;
            terminado <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (arranque) begin
                        bcd_reg   <= entrada_bcd;
                        bin_reg   <= '0;
                        signo_reg <= signo;
                        contador  <= '0;
                        if (digito_invalido) begin
                            estado <= FIN_ERR;
                        end else begin
                            estado  <= CONVERTIR;
                            ocupado <= 1'b1;
                        end
                    end
                end
                CONVERTIR: begin
                    bcd_reg <= bcd_corr;
                    bin_reg <= bin_desp;
                    if (contador == ULTIMO) begin
                        contador <= '0;
                        estado   <= FIN;
                    end else begin
                        contador <= contador + 1'b1;
                    end
                end
                FIN: begin
                    resultado_bin <= resultado_sig;
                    terminado     <= 1'b1;
                    error_bcd     <= 1'b0;
                    ocupado       <= 1'b0;
                    estado        <= REPOSO;
                end
                default: begin  // FIN_ERR
                    resultado_bin <= '0;
                    terminado     <= 1'b1;
                    error_bcd     <= 1'b1;
                    ocupado       <= 1'b0;
                    estado        <= REPOSO;
                end
            endcase
        end
    end

endmodule
